nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that feeds operands one nibble per clock into a single `four_bit_full_adder` and carries between nibbles through a register. It sits directly upstream of, and owns, the 4-bit adder datapath. Wide additions therefore reuse one small ripple adder rather than a WIDTH-bit combinational chain. It delivers a WIDTH-bit sum, final carry-out and two's-complement overflow with a start/done handshake.

---
 rtl/nibble_serial_pkg.sv | 16 +
 rtl/four_bit_full_adder.sv | 30 +++
 rtl/nibble_serial_adder.sv | 126 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nibble_serial_pkg;

  // Bits consumed per adder step.
  localparam int NIBBLE_W = 4;

  // Control FSM states of the serial adder.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } nsa_state_t;

endpackage

// File: rtl/four_bit_full_adder.sv
// 4-bit ripple-carry adder with carry-out and two's-complement overflow.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module four_bit_full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       overflow
);

  logic [4:0] carry;

  // Ripple the carry through four single-bit full adders.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout     = carry[4];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = carry[3] ^ carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit adder, one nibble per clock, with start/done handshake.
// Latency: start accepted at edge k -> nibbles written at edges k+1..k+NIB, done in the following cycle.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  // Operand width must split evenly into nibbles.
  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  nsa_state_t state_q, state_d;

  logic [WIDTH-1:0]    a_q, b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                carry_q;
  logic                cout_q, ovf_q;
  logic [IDX_W-1:0]    idx_q;

  logic [NIBBLE_W-1:0] a_nib, b_nib;
  logic [NIBBLE_W-1:0] fa_sum;
  logic                fa_cout, fa_ovf;
  logic                accept;
  logic                last_nib;

  // A new request is taken whenever we are not in the middle of a run.
  assign accept   = start && (state_q != RUN);
  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  // Select the current nibble of each captured operand.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  four_bit_full_adder u_fa4 (
    .a        (a_nib),
    .b        (b_nib),
    .cin      (carry_q),
    .sum      (fa_sum),
    .cout     (fa_cout),
    .overflow (fa_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: run for NIB cycles, then a single done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-nibble sum write-back and carry chaining between nibbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx_q == IDX_W'(i)) begin
          sum_q[i*NIBBLE_W +: NIBBLE_W] <= fa_sum;
        end
      end
      carry_q <= fa_cout;
      idx_q   <= idx_q + IDX_W'(1);
      // Flags come from the top nibble only; they hold their old value until then.
      if (last_nib) begin
        cout_q <= fa_cout;
        ovf_q  <= fa_ovf;
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH 16, 4 and 32.
// Latency: checks done position and busy length against the accepting edge.
// Backpressure: exercises ignored start during run and back-to-back start in done.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        start4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  logic        start32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32)
  );

  // Advance one clock and settle past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit add with result, done position, busy length and pulse width checks.
  task automatic add16(input logic [15:0] ta, input logic [15:0] tbv, input logic tcin,
                       input logic [15:0] es, input logic ec, input logic eo, input string nm);
    int done_at;
    int busy_n;
    a16 = ta; b16 = tbv; cin16 = tcin; start16 = 1'b1;
    cyc();
    start16 = 1'b0;
    done_at = 0;
    busy_n  = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done_at == 0) begin
        if (busy16) busy_n++;
        if (done16) done_at = c;
        else cyc();
      end
    end
    checks++;
    if (done_at !== 5) begin
      errors++;
      $display("FAIL %s done_cycle got %0d exp 5", nm, done_at);
    end
    checks++;
    if (busy_n !== 4) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d exp 4", nm, busy_n);
    end
    checks++;
    if (sum16 !== es) begin
      errors++;
      $display("FAIL %s sum got %h exp %h", nm, sum16, es);
    end
    checks++;
    if (cout16 !== ec) begin
      errors++;
      $display("FAIL %s cout got %b exp %b", nm, cout16, ec);
    end
    checks++;
    if (ovf16 !== eo) begin
      errors++;
      $display("FAIL %s overflow got %b exp %b", nm, ovf16, eo);
    end
    cyc();
    checks++;
    if (done16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done got done=%b busy=%b exp 0 0", nm, done16, busy16);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0) begin
      errors++;
      $display("FAIL reset16 got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
               busy16, done16, sum16, cout16, ovf16);
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 8'h0) begin
      errors++;
      $display("FAIL reset4 got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
               busy4, done4, sum4, cout4, ovf4);
    end
  endtask

  task automatic test_basic();
    add16(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_carry_cases();
    add16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    add16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    add16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    add16(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, "cin");
  endtask

  task automatic test_ignore_start();
    int done_at;
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
    cyc();
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
    cyc();
    start16 = 1'b0;
    done_at = 0;
    for (int c = 2; c <= 20; c++) begin
      if (done_at == 0) begin
        if (done16) done_at = c;
        else cyc();
      end
    end
    checks++;
    if (done_at !== 5) begin
      errors++;
      $display("FAIL ignore_start done_cycle got %0d exp 5", done_at);
    end
    checks++;
    if (sum16 !== 16'h3333 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start result got %h/%b/%b exp 3333/0/0", sum16, cout16, ovf16);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int done_at;
    a16 = 16'h0101; b16 = 16'h0202; cin16 = 1'b0; start16 = 1'b1;
    cyc();
    start16 = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done_at == 0) begin
        if (done16) done_at = c;
        else cyc();
      end
    end
    checks++;
    if (done_at == 0 || sum16 !== 16'h0303) begin
      errors++;
      $display("FAIL b2b_first got done_at=%0d sum=%h exp done and 0303", done_at, sum16);
    end
    // Start held high during the done cycle.
    a16 = 16'h4000; b16 = 16'h4000; start16 = 1'b1;
    cyc();
    start16 = 1'b0;
    checks++;
    if (busy16 !== 1'b1 || done16 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy16, done16);
    end
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done_at == 0) begin
        if (done16) done_at = c;
        else cyc();
      end
    end
    checks++;
    if (done_at !== 5) begin
      errors++;
      $display("FAIL b2b_second done_cycle got %0d exp 5", done_at);
    end
    checks++;
    if (sum16 !== 16'h8000 || cout16 !== 1'b0 || ovf16 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second result got %h/%b/%b exp 8000/0/1", sum16, cout16, ovf16);
    end
    cyc();
  endtask

  task automatic test_reset_abort();
    int done_n;
    a16 = 16'h1234; b16 = 16'h0FCD; cin16 = 1'b0; start16 = 1'b1;
    cyc();
    start16 = 1'b0;
    cyc();
    // Second run cycle: only the low nibble has been written over the old 8000.
    checks++;
    if (sum16 !== 16'h8001 || ovf16 !== 1'b1) begin
      errors++;
      $display("FAIL partial_sum got %h ovf=%b exp 8001 ovf=1", sum16, ovf16);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0) begin
      errors++;
      $display("FAIL abort got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
               busy16, done16, sum16, cout16, ovf16);
    end
    done_n = 0;
    for (int c = 0; c < 8; c++) begin
      if (done16 || busy16) done_n++;
      cyc();
    end
    checks++;
    if (done_n !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", done_n);
    end
  endtask

  task automatic test_width4();
    int done_at;
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done_at == 0) begin
        if (done4) done_at = c;
        else cyc();
      end
    end
    checks++;
    if (done_at !== 2) begin
      errors++;
      $display("FAIL w4 done_cycle got %0d exp 2", done_at);
    end
    checks++;
    if (sum4 !== 4'h1 || cout4 !== 1'b1 || ovf4 !== 1'b1) begin
      errors++;
      $display("FAIL w4 result got %h/%b/%b exp 1/1/1", sum4, cout4, ovf4);
    end
    cyc();
  endtask

  task automatic test_random16();
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;
    logic        eo;
    for (int n = 0; n < 100; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      eo   = (ra[15] == rb[15]) && (full[15] != ra[15]);
      add16(ra, rb, rc, full[15:0], full[16], eo, "rand16");
    end
  endtask

  task automatic test_random32();
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] full;
    logic        eo;
    int          done_at;
    for (int n = 0; n < 100; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      eo   = (ra[31] == rb[31]) && (full[31] != ra[31]);
      a32 = ra; b32 = rb; cin32 = rc; start32 = 1'b1;
      cyc();
      start32 = 1'b0;
      done_at = 0;
      for (int c = 1; c <= 20; c++) begin
        if (done_at == 0) begin
          if (done32) done_at = c;
          else cyc();
        end
      end
      checks++;
      if (done_at !== 9) begin
        errors++;
        $display("FAIL rand32 done_cycle got %0d exp 9", done_at);
      end
      checks++;
      if (sum32 !== full[31:0] || cout32 !== full[32] || ovf32 !== eo) begin
        errors++;
        $display("FAIL rand32 %h+%h+%b got %h/%b/%b exp %h/%b/%b",
                 ra, rb, rc, sum32, cout32, ovf32, full[31:0], full[32], eo);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_cases();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_width4();
    test_random16();
    test_random32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
